// File: rtl/bufmr_ce_seq_pkg.sv
// Shared types and constants for the multi-region clock-buffer CE sequencer.
// Contents:
//   state_e        - sequencer state encoding (3-bit)
//   MAX_REGIONS    - largest supported number of regional buffers
//   max3()         - maximum of three cycle counts
//   tmr_width()    - width of the phase timer for the given cycle counts
package bufmr_ce_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CE_OFF = 3'd1,
    ST_CLR    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  localparam int MAX_REGIONS = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Enough bits to hold the longest phase length minus one.
  function automatic int tmr_width(input int ce_off, input int clr, input int settle);
    int w;
    w = $clog2(max3(ce_off, clr, settle) + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bufmr_seq_timer.sv
// Phase timer: loadable down-counter that stops at zero.
// Ports:
//   clk_i       - clock
//   rst_ni      - synchronous active-low reset (count -> 0)
//   load_i      - load load_val_i this cycle (wins over decrement)
//   load_val_i  - value to load (phase length minus one)
//   zero_o      - count is zero
module bufmr_seq_timer #(
  parameter int TW = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  output logic          zero_o
);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bufmr_ce_seq.sv
// Multi-region clock-buffer enable sequencer. Drives the CE of a
// BUFMRCE-class buffer and the CLR of the regional buffers it feeds, always
// in the order CE low -> regional clear -> settle -> CE high. The same
// sequence (minus the CE-low phase) runs after reset so regional dividers
// start phase-aligned.
// Ports:
//   clk          - sequencer clock
//   rst_n        - synchronous active-low reset
//   start        - resync request, honoured only in IDLE with force_off low
//   region_mask  - regions to clear, captured with start
//   force_off    - level; holds CE low while high
//   bufmr_ce     - CE to the multi-region buffer
//   bufr_clr     - per-region CLR
//   busy         - sequence or hold in progress
//   done         - one-cycle pulse when CE returns high
module bufmr_ce_seq
  import bufmr_ce_seq_pkg::*;
#(
  parameter int NUM_REGIONS   = 2,
  parameter int CE_OFF_CYCLES = 2,
  parameter int CLR_CYCLES    = 3,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NUM_REGIONS-1:0] region_mask,
  input  logic                   force_off,
  output logic                   bufmr_ce,
  output logic [NUM_REGIONS-1:0] bufr_clr,
  output logic                   busy,
  output logic                   done
);

  if (NUM_REGIONS < 1 || NUM_REGIONS > MAX_REGIONS) begin : g_bad_regions
    $error("bufmr_ce_seq: NUM_REGIONS out of range 1..8");
  end
  if (CE_OFF_CYCLES < 1 || CLR_CYCLES < 1 || SETTLE_CYCLES < 1) begin : g_bad_cycles
    $error("bufmr_ce_seq: cycle counts must be >= 1");
  end

  localparam int TW = tmr_width(CE_OFF_CYCLES, CLR_CYCLES, SETTLE_CYCLES);
  // After reset the first CLR cycle has already elapsed when the timer gets
  // its first load, so that load is one shorter than a normal CLR entry.
  localparam int CLR_PWR_LEN = (CLR_CYCLES > 1) ? CLR_CYCLES - 2 : 0;

  localparam logic [TW-1:0] LD_CE_OFF = TW'(CE_OFF_CYCLES - 1);
  localparam logic [TW-1:0] LD_CLR    = TW'(CLR_CYCLES - 1);
  localparam logic [TW-1:0] LD_CLR_PU = TW'(CLR_PWR_LEN);
  localparam logic [TW-1:0] LD_SETTLE = TW'(SETTLE_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [NUM_REGIONS-1:0] mask_q, mask_d;
  logic                   pwr_q, pwr_d;
  logic                   ce_q, busy_q, done_q;
  logic [NUM_REGIONS-1:0] clr_q;
  logic                   ce_d, busy_d, done_d;
  logic [NUM_REGIONS-1:0] clr_d;

  logic                   tmr_load;
  logic [TW-1:0]          tmr_val;
  logic                   tmr_zero;

  bufmr_seq_timer #(.TW(TW)) u_timer (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    pwr_d    = pwr_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    if (force_off) begin
      state_d = ST_HOLD;
      pwr_d   = 1'b0;
      // Park the timer at zero for the hold.
      if (state_q != ST_HOLD) begin
        tmr_load = 1'b1;
        tmr_val  = '0;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d  = ST_CE_OFF;
            mask_d   = region_mask;
            tmr_load = 1'b1;
            tmr_val  = LD_CE_OFF;
          end
        end
        ST_CE_OFF: begin
          if (tmr_zero) begin
            state_d  = ST_CLR;
            tmr_load = 1'b1;
            tmr_val  = LD_CLR;
          end
        end
        ST_CLR: begin
          if (pwr_q) begin
            // First cycle out of reset: timer was reset, not loaded.
            pwr_d    = 1'b0;
            tmr_load = 1'b1;
            if (CLR_CYCLES == 1) begin
              state_d = ST_SETTLE;
              tmr_val = LD_SETTLE;
            end else begin
              tmr_val = LD_CLR_PU;
            end
          end else if (tmr_zero) begin
            state_d  = ST_SETTLE;
            tmr_load = 1'b1;
            tmr_val  = LD_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (tmr_zero) begin
            state_d = ST_IDLE;
          end
        end
        ST_HOLD: begin
          // CE is already low, so resume straight at the clear phase.
          state_d  = ST_CLR;
          mask_d   = '1;
          tmr_load = 1'b1;
          tmr_val  = LD_CLR;
        end
        default: begin
          state_d = ST_CLR;
          mask_d  = '1;
          pwr_d   = 1'b1;
        end
      endcase
    end

    ce_d   = (state_d == ST_IDLE);
    clr_d  = (state_d == ST_CLR) ? mask_d : '0;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_SETTLE) && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_CLR;
      mask_q  <= '1;
      pwr_q   <= 1'b1;
      ce_q    <= 1'b0;
      clr_q   <= '1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pwr_q   <= pwr_d;
      ce_q    <= ce_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bufmr_ce = ce_q;
  assign bufr_clr = clr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_bufmr_ce_seq.sv
module tb_bufmr_ce_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] region_mask;
  logic       force_off;
  logic       bufmr_ce;
  logic [3:0] bufr_clr;
  logic       busy;
  logic       done;

  int checks;
  int errors;

  bufmr_ce_seq #(
    .NUM_REGIONS   (4),
    .CE_OFF_CYCLES (2),
    .CLR_CYCLES    (3),
    .SETTLE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .region_mask (region_mask),
    .force_off   (force_off),
    .bufmr_ce    (bufmr_ce),
    .bufr_clr    (bufr_clr),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to the next cycle; outputs are read 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic ce, input logic [3:0] clr,
                          input logic bsy, input logic dn);
    chk({tag, ".ce"},   {31'd0, bufmr_ce}, {31'd0, ce});
    chk({tag, ".clr"},  {28'd0, bufr_clr}, {28'd0, clr});
    chk({tag, ".busy"}, {31'd0, busy},     {31'd0, bsy});
    chk({tag, ".done"}, {31'd0, done},     {31'd0, dn});
  endtask

  // Called in cycle 1 after reset release; checks cycles 1..9.
  task automatic chk_powerup(input string tag);
    for (int c = 1; c <= 9; c++) begin
      chk_outs($sformatf("%s.c%0d", tag, c), (c == 8 || c == 9),
               (c <= 3) ? 4'hF : 4'h0, (c < 8), (c == 8));
      if (c < 9) tick();
    end
  endtask

  // Issue start at edge 0 and check cycles 1..14. If busy_start>0 a second
  // start is pulsed during that cycle and must be ignored.
  task automatic run_seq(input string tag, input logic [3:0] mask, input int busy_start);
    int ndone;
    ndone = 0;
    region_mask = mask;
    start = 1'b1;
    tick();
    start = 1'b0;
    region_mask = 4'h0;
    for (int c = 1; c <= 14; c++) begin
      chk_outs($sformatf("%s.c%0d", tag, c), (c >= 10),
               (c >= 3 && c <= 5) ? mask : 4'h0, (c < 10), (c == 10));
      if (done) ndone++;
      if (c == busy_start) begin
        start = 1'b1;
        region_mask = 4'hF;
      end else begin
        start = 1'b0;
      end
      if (c < 14) tick();
    end
    start = 1'b0;
    chk({tag, ".ndone"}, ndone, 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    region_mask = 4'h0;
    force_off = 1'b0;

    // Reset held for 5 cycles.
    for (int i = 0; i < 5; i++) tick();
    chk_outs("rst", 1'b0, 4'hF, 1'b1, 1'b0);
    rst_n = 1'b1;
    chk_powerup("pwr");

    // Masked resync, then a start while busy.
    run_seq("mask5", 4'b0101, 0);
    run_seq("busy_st", 4'b1010, 4);

    // Force-off during SETTLE.
    region_mask = 4'b0011;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    chk_outs("fo.settle", 1'b0, 4'h0, 1'b1, 1'b0);
    force_off = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk_outs($sformatf("fo.hold%0d", c), 1'b0, 4'h0, 1'b1, 1'b0);
    end
    force_off = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk_outs($sformatf("fo.rel%0d", c), (c >= 8),
               (c <= 3) ? 4'hF : 4'h0, (c < 8), (c == 8));
    end

    // Start ignored while force_off is high in IDLE.
    force_off = 1'b1;
    start = 1'b1;
    region_mask = 4'hF;
    tick();
    start = 1'b0;
    chk_outs("fo.idle", 1'b0, 4'h0, 1'b1, 1'b0);
    force_off = 1'b0;
    for (int c = 1; c <= 8; c++) tick();
    chk_outs("fo.idle.done", 1'b1, 4'h0, 1'b0, 1'b1);
    tick();

    // Reset for one cycle in the middle of CLR, with start asserted.
    region_mask = 4'b0110;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk_outs("mid.clr", 1'b0, 4'b0110, 1'b1, 1'b0);
    rst_n = 1'b0;
    start = 1'b1;
    region_mask = 4'hF;
    tick();
    rst_n = 1'b1;
    start = 1'b0;
    chk_powerup("mid.pwr");
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_outs($sformatf("mid.quiet%0d", c), 1'b1, 4'h0, 1'b0, 1'b0);
    end

    // All-zero mask still runs full timing.
    run_seq("zero", 4'b0000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bufmr_ce_seq.md
# bufmr_ce_seq

Parametrised multi-region clock-buffer enable sequencer for the clocking layer of the PCIe endpoint. It drives the CE of a multi-region buffer (BUFMRCE-class) and the CLR inputs of the NUM_REGIONS regional buffers it feeds. Every enable, re-enable and forced-off episode uses the safe order: CE low, then regional clear, then settle, then CE high. It also runs this sequence automatically after reset, so regional dividers start phase-aligned.

## Interface
Parameters:
- NUM_REGIONS, 2: number of regional buffers driven; legal range 1..8.
- CE_OFF_CYCLES, 2: cycles CE is held low before clear asserts; must be ≥1.
- CLR_CYCLES, 3: cycles clear is held; must be ≥1.
- SETTLE_CYCLES, 4: cycles between clear release and CE re-assert; must be ≥1.

Ports:
- clk  in  1  sequencer clock (free-running, independent of the buffered clock).
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- start  in  1  request a resync; sampled only in IDLE.
- region_mask  in  NUM_REGIONS  regions to clear; captured with start.
- force_off  in  1  level; hold CE low while high.
- bufmr_ce  out  1  CE to the multi-region buffer.
- bufr_clr  out  NUM_REGIONS  per-region CLR.
- busy  out  1  a sequence or hold is in progress.
- done  out  1  one-cycle pulse when CE returns high.

## Operation
- States: IDLE, CE_OFF, CLR, SETTLE, HOLD.
- All outputs are registered.
- Reset values while rst_n=0: bufmr_ce=0, bufr_clr=all ones, busy=1, done=0, state=CLR, captured mask=all ones, timer=0.
- IDLE: bufmr_ce=1, bufr_clr=0, busy=0. If start=1 and force_off=0, capture region_mask and go to CE_OFF.
- CE_OFF: bufmr_ce=0 for CE_OFF_CYCLES cycles, then go to CLR.
- CLR: bufr_clr=captured mask for CLR_CYCLES cycles, then go to SETTLE.
- SETTLE: bufr_clr=0 and bufmr_ce=0 for SETTLE_CYCLES cycles. Then go to IDLE, with done=1 and bufmr_ce=1 in that first IDLE cycle.
- HOLD: force_off=1 in any state moves to HOLD on the next cycle, with bufmr_ce=0, bufr_clr=0, busy=1. It stays there while force_off=1. On release, capture mask=all ones and enter CLR; the CE_OFF phase is skipped because CE is already low.
- start while busy, or while force_off=1, is ignored. It is not queued.
- A mask of all zeros still runs the full timing; bufr_clr simply never rises.
- Priority, highest first: rst_n, then force_off, then timer expiry, then start.
- Illegal parameters (zero cycle counts, NUM_REGIONS out of range) must fail at elaboration.

## Timing
- Take start=1 sampled in IDLE at edge 0, and let T=CE_OFF_CYCLES+CLR_CYCLES+SETTLE_CYCLES.
  - bufmr_ce=0 during cycles 1..T.
  - bufr_clr=mask during cycles CE_OFF_CYCLES+1 .. CE_OFF_CYCLES+CLR_CYCLES.
  - bufmr_ce=1 and done=1 in cycle T+1.
  - busy=1 during cycles 1..T; busy=0 in the done cycle.
- Power-up: take cycle 1 as the first cycle with rst_n=1.
  - bufr_clr stays high through cycle CLR_CYCLES.
  - CE and done rise in cycle CLR_CYCLES+SETTLE_CYCLES+1.
- Timer: one down-counter of width $clog2(max cycle param + 1).
  - It is loaded with (phase length − 1) on entry to each phase.
  - The phase exits when the counter is 0.
  - It does not wrap: it holds at 0 in IDLE and HOLD.
- rst_n low mid-sequence: the reset values apply in the next cycle. The power-up sequence restarts after release.

## Structure
- Package bufmr_ce_seq_pkg holds:
  - the state enum (3-bit: IDLE, CE_OFF, CLR, SETTLE, HOLD);
  - a localparam function computing the timer width;
  - the maximum NUM_REGIONS constant (8).
- One natural sub-module, bufmr_seq_timer: a load/decrement down-counter with a zero flag, parametrised by width.
- The FSM and output registers live in bufmr_ce_seq.

## Test plan
Use NUM_REGIONS=4, CE_OFF=2, CLR=3, SETTLE=4.
- Reset and power-up: hold rst_n=0 for 5 cycles → ce=0, clr=1111, busy=1. After release: clr=1111 in cycles 1–3, clr=0 from cycle 4, ce=1 and done=1 in cycle 8, busy=0 in cycle 8.
- Masked resync: start with mask=0101 at edge 0 → ce=0 in cycles 1–9, clr=0101 in cycles 3–5, done and ce=1 in cycle 10, exactly one done pulse.
- Start while busy: a second start at cycle 4 is ignored; done occurs only in cycle 10, and no second sequence runs.
- Force-off: force_off=1 during SETTLE for 20 cycles → ce=0, clr=0, busy=1 throughout. On release: clr=1111 for 3 cycles, 4 settle cycles, then done with ce=1.
- Reset mid-CLR: rst_n=0 for 1 cycle during CLR → next cycle shows clr=1111, ce=0, busy=1. The power-up timing from the first scenario then repeats. A start asserted during reset has no effect.
- Zero mask: start with mask=0000 → clr stays 0000, ce=0 for 9 cycles, done in cycle 10.
